// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle interface plus the shared op_pkg widths.
// The master side is fetch/decode (the environment); the slave side is
// the fetch_queue that buffers bundles between them.
`timescale 1ns/1ps

package op_pkg;
  localparam int INSTRUCTION_WIDTH  = 32;
  localparam int SUPER_SCALAR_WIDTH = 4;
endpackage

interface fetch_queue_if #(
  parameter int INSTRUCTION_WIDTH  = op_pkg::INSTRUCTION_WIDTH,
  parameter int SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter int DEPTH              = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                                                flush_in;
  logic                                                fetch_valid_in;
  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] fetched_instrs_in;
  logic [63:0]                                         fetch_pc_in;
  logic                                                decode_ready_out;
  logic                                                decode_ready_in;
  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] instrs_out;
  logic [SUPER_SCALAR_WIDTH-1:0][63:0]                 lane_pc_out;
  logic [SUPER_SCALAR_WIDTH-1:0]                       lane_valid_out;
  logic                                                valid_out;
  logic [CNT_W-1:0]                                    count_out;

  // Environment side: fetch pushes bundles, decode pops them.
  modport master (
    output flush_in, fetch_valid_in, fetched_instrs_in, fetch_pc_in, decode_ready_in,
    input  decode_ready_out, instrs_out, lane_pc_out, lane_valid_out, valid_out, count_out
  );

  // Queue side.
  modport slave (
    input  flush_in, fetch_valid_in, fetched_instrs_in, fetch_pc_in, decode_ready_in,
    output decode_ready_out, instrs_out, lane_pc_out, lane_valid_out, valid_out, count_out
  );
endinterface

// File: rtl/fetch_queue.sv
// Decode-side bundle FIFO. Buffers fetch bundles in a circular queue,
// drives backpressure to fetch and presents the head bundle to decode with
// per-lane PCs and NOP-filtered lane valids. A flush empties the queue.
`timescale 1ns/1ps

module fetch_queue #(
  parameter int                           INSTRUCTION_WIDTH  = op_pkg::INSTRUCTION_WIDTH,
  parameter int                           SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter int                           DEPTH              = 4,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_ENCODING       = INSTRUCTION_WIDTH'(32'hD503201F)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] bundle_t;

  bundle_t            instr_mem [DEPTH];
  logic [63:0]        pc_mem    [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               ready;
  logic               not_empty;
  logic               enq;
  logic               deq;

  // Backpressure and handshakes depend only on registered state (and reset),
  // so there is no combinational loop through fetch or decode.
  assign ready     = !rst_in && (count < CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign enq       = bus.fetch_valid_in && ready && !bus.flush_in;
  assign deq       = not_empty && bus.decode_ready_in && !bus.flush_in;

  // Pointer and occupancy update; flush wins over enqueue and dequeue.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Bundle storage written at the tail on enqueue.
  // NOTE: the data array is deliberately not reset; validity is tracked by
  // the pointers and count, so stale contents are never observed.
  always_ff @(posedge clk_in) begin
    if (enq) begin
      instr_mem[tail] <= bus.fetched_instrs_in;
      pc_mem[tail]    <= bus.fetch_pc_in;
    end
  end

  assign bus.decode_ready_out = ready;
  assign bus.valid_out        = not_empty;
  assign bus.count_out        = count;
  assign bus.instrs_out       = instr_mem[head];

  // Per-lane PC and valid derived from the head entry.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    bus.lane_pc_out    = '0;
    bus.lane_valid_out = '0;
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      bus.lane_pc_out[i]    = pc_mem[head] + 64'(4 * i);
      bus.lane_valid_out[i] = not_empty && (instr_mem[head][i] != NOP_ENCODING);
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decode-side receiver for the fetch-to-decode interface. It accepts registered instruction bundles (SUPER_SCALAR_WIDTH instructions plus their predicted PC) from fetch and buffers them in a circular FIFO. It drives the ready backpressure that fetch samples as its decode-ready input, and presents one bundle per cycle to decode with per-lane valid bits and per-lane PCs. A misprediction flush empties the queue.

## Interface
- INSTRUCTION_WIDTH, default op_pkg::INSTRUCTION_WIDTH: bits per instruction.
- SUPER_SCALAR_WIDTH, default op_pkg::SUPER_SCALAR_WIDTH: instructions per bundle.
- DEPTH, default 4: number of bundle entries; a power of two, at least 2.
- NOP_ENCODING, default 32'hD503201F: fetch's pad encoding; lanes holding it are reported invalid.
- clk_in  input  1  single clock; all state is updated on the rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- flush_in  input  1  misprediction flush.
- fetch_valid_in  input  1  fetch bundle valid.
- fetched_instrs_in  input  [INSTRUCTION_WIDTH-1:0] x SUPER_SCALAR_WIDTH  bundle; lane 0 is at the lowest address.
- fetch_pc_in  input  64  PC of lane 0.
- decode_ready_out  output  1  queue can accept a bundle (goes to fetch's decode_ready).
- decode_ready_in  input  1  decode consumes the head bundle this cycle.
- instrs_out  output  [INSTRUCTION_WIDTH-1:0] x SUPER_SCALAR_WIDTH  head bundle.
- lane_pc_out  output  64 x SUPER_SCALAR_WIDTH  lane i PC = head PC + 4*i, modulo 2^64.
- lane_valid_out  output  SUPER_SCALAR_WIDTH  lane i valid = valid_out AND instrs_out[i] != NOP_ENCODING.
- valid_out  output  1  head bundle present.
- count_out  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries, each holding one bundle and its PC. Head and tail pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. A separate count register is kept.
- decode_ready_out = !rst_in && (count < DEPTH). It is combinational from registered state and never depends on decode_ready_in.
- Enqueue when fetch_valid_in && decode_ready_out && !flush_in: write the bundle at tail, then tail+1.
- Dequeue when valid_out && decode_ready_in && !flush_in: head+1.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Full (count == DEPTH): no enqueue, even if a dequeue happens in the same cycle. There is no pass-through.
- Empty (count == 0): valid_out = 0, lane_valid_out = 0, and instrs_out/lane_pc_out are don't-care. decode_ready_in is ignored.
- There is no bypass: an empty queue never forwards the input straight to the outputs.
- Flush: head, tail and count are cleared to 0 at the edge. An enqueue or dequeue presented in the flush cycle is discarded or not performed.
- The flush takes priority over all other events.
- Stored entry contents are not cleared by a flush.
- Bundles whose lanes are all NOP are still enqueued; every lane_valid_out bit is 0 for them.

## Timing
- Reset (asynchronous, immediate on rst_in rising): head, tail and count go to 0.
- Outputs while rst_in is high: valid_out = 0, lane_valid_out = 0, count_out = 0, decode_ready_out = 0.
- decode_ready_out = 1 in the first cycle after rst_in deasserts. Releasing reset is synchronous to clk_in from the environment's side.
- Enqueue-to-output latency is 1 cycle: a bundle accepted at edge T appears on valid_out/instrs_out after T, provided the queue was empty.
- Outputs are driven combinationally from the head entry and registered pointers. There is no combinational path from any input to valid_out, instrs_out or decode_ready_out, except rst_in.
- Fetch registers its outputs only while decode_ready_out is high. The queue must therefore sample fetch_valid_in only in cycles where decode_ready_out is high; a held bundle is not double-counted.
- After a flush at edge T: count_out = 0 and decode_ready_out = 1 in the cycle following T.
- Reset in the middle of operation discards all contents. There is no partial state.

## Test plan
All scenarios use SUPER_SCALAR_WIDTH=4, DEPTH=4 and INSTRUCTION_WIDTH=32.
- Reset behaviour: assert rst_in between edges -> count_out=0, valid_out=0, decode_ready_out=0 immediately. After release: decode_ready_out=1 and valid_out=0.
- Single bundle: enqueue {0x11,0x22,0xD503201F,0x44} at PC 0x1000, with decode_ready_in=0 -> next cycle valid_out=1, lane_valid_out=4'b1011, lane_pc_out={0x1000,0x1004,0x1008,0x100C}, count_out=1.
- Fill and backpressure: enqueue 4 bundles with decode_ready_in=0 -> count_out=4 and decode_ready_out=0. A fifth fetch_valid_in is not accepted. With decode_ready_in=1 and fetch_valid_in=1 held, one dequeue occurs, count_out=3, and no enqueue happens that cycle.
- Wrap-around: stream 10 bundles with PCs 0x0,0x40,…,0x240 while decode_ready_in toggles 1,0,1,0 -> decode sees the PCs in order with no loss or duplication, and the pointers wrap at least twice.
- Simultaneous enqueue and dequeue at count 2 -> count stays 2 and the head advances to the next PC.
- Flush with valid input and dequeue pending at count 3 -> next cycle count_out=0, valid_out=0, decode_ready_out=1. The flushed-cycle bundle never appears at the output.
